// File: rtl/audio_pkg.sv
// Shared constants for the audio tone path: silence level, 48-entry sine table, FSM states
// and the volume scaler.
package audio_pkg;

  localparam int unsigned SINE_LEN = 48;
  localparam logic [15:0] SILENCE  = 16'h8000;

  // One 1 kHz period at 48 kHz, offset-binary, starting at the trough.
  localparam logic [15:0] SINE_TABLE [SINE_LEN] = '{
    16'd0,     16'd280,   16'd1116,  16'd2494,  16'd4390,  16'd6771,
    16'd9597,  16'd12820, 16'd16384, 16'd20228, 16'd24287, 16'd28490,
    16'd32768, 16'd37045, 16'd41248, 16'd45307, 16'd49152, 16'd52715,
    16'd55938, 16'd58764, 16'd61145, 16'd63041, 16'd64419, 16'd65255,
    16'd65535, 16'd65255, 16'd64419, 16'd63041, 16'd61145, 16'd58764,
    16'd55938, 16'd52715, 16'd49152, 16'd45307, 16'd41248, 16'd37045,
    16'd32768, 16'd28490, 16'd24287, 16'd20228, 16'd16384, 16'd12820,
    16'd9597,  16'd6771,  16'd4390,  16'd2494,  16'd1116,  16'd280
  };

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  // Attenuate around mid-scale so silence stays at 16'h8000 for every volume.
  function automatic logic [15:0] scale_sample(input logic [15:0] raw, input logic [1:0] vol);
    logic signed [16:0] s;
    s = $signed({1'b0, raw}) - 17'sd32768;
    s = s >>> vol;
    s = s + 17'sd32768;
    return s[15:0];
  endfunction

endpackage

// File: rtl/audio_sine_rom.sv
// Combinational sine lookup; out-of-range addresses read as silence.
module audio_sine_rom
  import audio_pkg::*;
(
  input  logic [5:0]  addr_i,
  output logic [15:0] data_o
);

  always_comb begin
    data_o = SILENCE;
    if (addr_i < 6'(SINE_LEN)) begin
      data_o = SINE_TABLE[addr_i];
    end
  end

endmodule

// File: rtl/audio_tone_sequencer.sv
// Command-driven tone generator: plays (step, duration, volume) notes from the sine table,
// one registered sample per 48 kHz clock.
module audio_tone_sequencer
  import audio_pkg::*;
#(
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned DUR_W  = 16
) (
  input  logic                I_clk_audio,
  input  logic                I_reset_n,
  input  logic                I_cmd_valid,
  output logic                O_cmd_ready,
  input  logic [6+FRAC_W-1:0] I_cmd_step,
  input  logic [DUR_W-1:0]    I_cmd_dur,
  input  logic [1:0]          I_cmd_vol,
  input  logic                I_stop,
  output logic                O_busy,
  output logic [15:0]         O_sample
);

  localparam int unsigned PhaseW = 6 + FRAC_W;
  localparam logic [PhaseW:0]   Wrap    = (PhaseW + 1)'(SINE_LEN << FRAC_W);
  localparam logic [PhaseW-1:0] StepMax = PhaseW'(SINE_LEN << FRAC_W);

  state_e              state_q, state_d;
  logic [PhaseW-1:0]   phase_q, phase_d, step_q, step_d, phase_next;
  logic [PhaseW:0]     phase_sum;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [1:0]          vol_q, vol_d;
  logic                rest_q, rest_d;
  logic [15:0]         sample_q, sample_d, rom_data;
  logic                last, accept, load;

  audio_sine_rom u_rom (
    .addr_i (phase_q[PhaseW-1:FRAC_W]),
    .data_o (rom_data)
  );

  assign last        = (dur_q == DUR_W'(1));
  assign O_cmd_ready = (state_q == IDLE) || ((state_q == PLAY) && last && !I_stop);
  assign accept      = I_cmd_valid && O_cmd_ready;
  assign load        = accept && (I_cmd_dur != '0);

  // Wide sum so a step near the table length cannot overflow before the exact wrap.
  assign phase_sum  = {1'b0, phase_q} + {1'b0, step_q};
  assign phase_next = (phase_sum >= Wrap) ? PhaseW'(phase_sum - Wrap) : PhaseW'(phase_sum);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    step_d   = step_q;
    dur_d    = dur_q;
    vol_d    = vol_q;
    rest_d   = rest_q;
    sample_d = sample_q;

    unique case (state_q)
      IDLE: begin
        sample_d = SILENCE;
      end
      PLAY: begin
        if (I_stop) begin
          state_d  = IDLE;
          sample_d = SILENCE;
        end else begin
          sample_d = rest_q ? SILENCE : scale_sample(rom_data, vol_q);
          phase_d  = phase_next;
          dur_d    = dur_q - DUR_W'(1);
          if (last && !load) begin
            state_d = IDLE;
          end
        end
      end
    endcase

    // Ready is only high in IDLE or on the final sample, so this covers both entry paths.
    if (load) begin
      state_d = PLAY;
      phase_d = '0;
      step_d  = I_cmd_step;
      dur_d   = I_cmd_dur;
      vol_d   = I_cmd_vol;
      rest_d  = (I_cmd_step == '0);
    end
  end

  always_ff @(posedge I_clk_audio or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      step_q   <= '0;
      dur_q    <= '0;
      vol_q    <= '0;
      rest_q   <= 1'b0;
      sample_q <= SILENCE;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      step_q   <= step_d;
      dur_q    <= dur_d;
      vol_q    <= vol_d;
      rest_q   <= rest_d;
      sample_q <= sample_d;
    end
  end

  assign O_busy   = (state_q == PLAY);
  assign O_sample = sample_q;

  step_legal_a: assert property (@(posedge I_clk_audio) disable iff (!I_reset_n)
    (I_cmd_valid && O_cmd_ready && (I_cmd_dur != '0)) |-> (I_cmd_step < StepMax));

endmodule

// File: tb/tb_audio_tone_sequencer.sv
// Directed bench for audio_tone_sequencer: per-cycle vector table plus hand sequences.
module tb_audio_tone_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [13:0] step;
  logic [15:0] dur;
  logic [1:0]  vol;
  logic        stop;
  logic        busy;
  logic [15:0] sample;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [15:0] EXP_TAB [48] = '{
    16'd0,     16'd280,   16'd1116,  16'd2494,  16'd4390,  16'd6771,
    16'd9597,  16'd12820, 16'd16384, 16'd20228, 16'd24287, 16'd28490,
    16'd32768, 16'd37045, 16'd41248, 16'd45307, 16'd49152, 16'd52715,
    16'd55938, 16'd58764, 16'd61145, 16'd63041, 16'd64419, 16'd65255,
    16'd65535, 16'd65255, 16'd64419, 16'd63041, 16'd61145, 16'd58764,
    16'd55938, 16'd52715, 16'd49152, 16'd45307, 16'd41248, 16'd37045,
    16'd32768, 16'd28490, 16'd24287, 16'd20228, 16'd16384, 16'd12820,
    16'd9597,  16'd6771,  16'd4390,  16'd2494,  16'd1116,  16'd280
  };

  typedef struct {
    logic        valid;
    logic [13:0] step;
    logic [15:0] dur;
    logic [1:0]  vol;
    logic        stop;
    logic        exp_ready;
    logic [15:0] exp_sample;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];

  audio_tone_sequencer dut (
    .I_clk_audio (clk),
    .I_reset_n   (rst_n),
    .I_cmd_valid (valid),
    .O_cmd_ready (ready),
    .I_cmd_step  (step),
    .I_cmd_dur   (dur),
    .I_cmd_vol   (vol),
    .I_stop      (stop),
    .O_busy      (busy),
    .O_sample    (sample)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [15:0] exp_s, input logic exp_b);
    check({name, " sample"}, sample, exp_s);
    check({name, " busy"}, {15'd0, busy}, {15'd0, exp_b});
  endtask

  task automatic set_cmd(input logic v, input logic [13:0] st, input logic [15:0] d,
                         input logic [1:0] vl);
    valid = v;
    step  = st;
    dur   = d;
    vol   = vl;
  endtask

  function automatic vec_t mk(input logic v, input logic [13:0] st, input logic [15:0] d,
                              input logic [1:0] vl, input logic sp, input logic er,
                              input logic [15:0] es, input logic eb);
    vec_t r;
    r.valid = v; r.step = st; r.dur = d; r.vol = vl; r.stop = sp;
    r.exp_ready = er; r.exp_sample = es; r.exp_busy = eb;
    return r;
  endfunction

  initial begin
    rst_n = 1'b0;
    stop  = 1'b0;
    set_cmd(1'b0, 14'd0, 16'd0, 2'd0);
    repeat (3) @(posedge clk);
    #1;
    check_out("in reset", 16'h8000, 1'b0);
    check("in reset ready", {15'd0, ready}, 16'd1);
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 100; i++) begin
      tick();
      check_out($sformatf("idle c%0d", i), 16'h8000, 1'b0);
      check($sformatf("idle c%0d ready", i), {15'd0, ready}, 16'd1);
    end

    // Full period at 1 kHz, full volume
    set_cmd(1'b1, 14'd256, 16'd48, 2'd0);
    check("t2 ready", {15'd0, ready}, 16'd1);
    tick();
    set_cmd(1'b0, 14'd0, 16'd0, 2'd0);
    check_out("t2 accept", 16'h8000, 1'b1);
    for (int i = 0; i < 48; i++) begin
      tick();
      check_out($sformatf("t2 s%0d", i), EXP_TAB[i], i < 47);
      check($sformatf("t2 s%0d ready", i), {15'd0, ready}, {15'd0, i >= 46});
    end
    tick();
    check_out("t2 after", 16'h8000, 1'b0);

    // Vector table: step=512 at half volume, a rest, then a dropped zero-length command
    vecs.push_back(mk(1'b1, 14'd512, 16'd4, 2'd1, 1'b0, 1'b1, 16'h8000, 1'b1));
    vecs.push_back(mk(1'b0, 14'd0, 16'd0, 2'd0, 1'b0, 1'b0, 16'd16384, 1'b1));
    vecs.push_back(mk(1'b0, 14'd0, 16'd0, 2'd0, 1'b0, 1'b0, 16'd16942, 1'b1));
    vecs.push_back(mk(1'b0, 14'd0, 16'd0, 2'd0, 1'b0, 1'b0, 16'd18579, 1'b1));
    vecs.push_back(mk(1'b0, 14'd0, 16'd0, 2'd0, 1'b0, 1'b1, 16'd21182, 1'b0));
    vecs.push_back(mk(1'b0, 14'd0, 16'd0, 2'd0, 1'b0, 1'b1, 16'h8000, 1'b0));
    vecs.push_back(mk(1'b1, 14'd0, 16'd10, 2'd0, 1'b0, 1'b1, 16'h8000, 1'b1));
    for (int i = 0; i < 10; i++) begin
      vecs.push_back(mk(1'b0, 14'd0, 16'd0, 2'd0, 1'b0, i == 9, 16'h8000, i < 9));
    end
    vecs.push_back(mk(1'b1, 14'd256, 16'd0, 2'd0, 1'b0, 1'b1, 16'h8000, 1'b0));
    vecs.push_back(mk(1'b0, 14'd0, 16'd0, 2'd0, 1'b0, 1'b1, 16'h8000, 1'b0));
    vecs.push_back(mk(1'b0, 14'd0, 16'd0, 2'd0, 1'b0, 1'b1, 16'h8000, 1'b0));

    foreach (vecs[i]) begin
      set_cmd(vecs[i].valid, vecs[i].step, vecs[i].dur, vecs[i].vol);
      stop = vecs[i].stop;
      check($sformatf("vec%0d ready", i), {15'd0, ready}, {15'd0, vecs[i].exp_ready});
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].exp_sample, vecs[i].exp_busy);
    end
    set_cmd(1'b0, 14'd0, 16'd0, 2'd0);
    stop = 1'b0;

    // Back-to-back: second note accepted on the last sample of the first
    set_cmd(1'b1, 14'd256, 16'd3, 2'd0);
    tick();
    set_cmd(1'b0, 14'd0, 16'd0, 2'd0);
    tick();
    check_out("b2b a0", EXP_TAB[0], 1'b1);
    tick();
    check_out("b2b a1", EXP_TAB[1], 1'b1);
    set_cmd(1'b1, 14'd1024, 16'd2, 2'd2);
    check("b2b ready on last", {15'd0, ready}, 16'd1);
    tick();
    set_cmd(1'b0, 14'd0, 16'd0, 2'd0);
    check_out("b2b a2", EXP_TAB[2], 1'b1);
    tick();
    check_out("b2b b0", 16'd24576, 1'b1);
    tick();
    check_out("b2b b1", 16'd25673, 1'b0);
    tick();
    check_out("b2b end", 16'h8000, 1'b0);

    // Stop beats a simultaneous command mid-note
    set_cmd(1'b1, 14'd256, 16'd20, 2'd0);
    tick();
    set_cmd(1'b0, 14'd0, 16'd0, 2'd0);
    repeat (3) tick();
    check_out("stop pre", EXP_TAB[2], 1'b1);
    stop = 1'b1;
    set_cmd(1'b1, 14'd512, 16'd5, 2'd0);
    check("stop ready", {15'd0, ready}, 16'd0);
    tick();
    stop = 1'b0;
    set_cmd(1'b0, 14'd0, 16'd0, 2'd0);
    check_out("stop next", 16'h8000, 1'b0);
    tick();
    check_out("stop idle", 16'h8000, 1'b0);

    // Asynchronous reset mid-note
    set_cmd(1'b1, 14'd256, 16'd20, 2'd0);
    tick();
    set_cmd(1'b0, 14'd0, 16'd0, 2'd0);
    repeat (5) tick();
    check_out("rst pre", EXP_TAB[4], 1'b1);
    set_cmd(1'b1, 14'd512, 16'd5, 2'd0);
    rst_n = 1'b0;
    #1;
    check_out("rst async", 16'h8000, 1'b0);
    check("rst async ready", {15'd0, ready}, 16'd1);
    set_cmd(1'b0, 14'd0, 16'd0, 2'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check_out("rst after", 16'h8000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
